// File: rtl/fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_op_sequencer
//
// Initiator for the FPU start/done protocol. One command (opcode + two
// IEEE-754 operands) is accepted at a time. The operands are presented to the
// FPU and the FPU start line (the FPU's own reset input) is pulsed high for
// START_CYCLES cycles. The block then waits for a rising edge on fpu_done,
// captures fpu_result and offers it on the response channel. If no completion
// arrives within TIMEOUT_CYCLES cycles, a response with rsp_timeout=1 and a
// zero result is produced instead.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge. Neither ready is allowed to depend on the valid of the same channel.
//
// Ports
//   Clk, Reset           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op, cmd_a, cmd_b command payload (00 add, 01 sub, 10 mul, 11 div)
//   fpu_a, fpu_b, fpu_op operands/opcode driven to the FPU
//   fpu_start            FPU reset/start pulse
//   fpu_result, fpu_done FPU result and completion level
//   rsp_valid/rsp_ready  response handshake
//   rsp_result, rsp_op   captured result and its opcode
//   rsp_timeout          response was produced by the timeout
//   busy                 an operation is in flight (state != IDLE)
//   dbg_state            current FSM state encoding
// -----------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int PRECISION      = 32,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [PRECISION-1:0] cmd_a,
  input  logic [PRECISION-1:0] cmd_b,
  output logic [PRECISION-1:0] fpu_a,
  output logic [PRECISION-1:0] fpu_b,
  output logic [1:0]           fpu_op,
  output logic                 fpu_start,
  input  logic [PRECISION-1:0] fpu_result,
  input  logic                 fpu_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PRECISION-1:0] rsp_result,
  output logic [1:0]           rsp_op,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // One counter serves both the launch pulse and the wait timeout, so it is
  // sized for whichever limit is larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   fpu_start_q, fpu_start_d;
  logic [PRECISION-1:0]   fpu_a_q, fpu_a_d;
  logic [PRECISION-1:0]   fpu_b_q, fpu_b_d;
  logic [1:0]             fpu_op_q, fpu_op_d;
  logic [PRECISION-1:0]   rsp_result_q, rsp_result_d;
  logic [1:0]             rsp_op_q, rsp_op_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic                   done_event;

  // Only a low-to-high transition of Done counts as completion; a level left
  // over from a previous operation must not complete the current one.
  assign done_event = fpu_done & ~done_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = fpu_done;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    fpu_op_d      = fpu_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          fpu_a_d  = cmd_a;
          fpu_b_d  = cmd_b;
          fpu_op_d = cmd_op;
          cnt_d    = '0;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        // Done activity here belongs to the FPU being reset and is ignored;
        // done_q still tracks it so the edge detector is primed for WAIT.
        if (cnt_q == LAUNCH_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion is tested first so that it wins over a same-cycle timeout.
        if (done_event) begin
          rsp_result_d  = fpu_result;
          rsp_op_d      = fpu_op_q;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == WAIT_LAST) begin
          rsp_result_d  = '0;
          rsp_op_d      = fpu_op_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The start line is registered so it is glitch-free towards the FPU and
    // still drops immediately when Reset is asserted.
    fpu_start_d = (state_d == S_LAUNCH);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      fpu_start_q   <= 1'b0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      fpu_op_q      <= '0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      fpu_start_q   <= fpu_start_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      fpu_op_q      <= fpu_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
  assign fpu_start   = fpu_start_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign fpu_op      = fpu_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
